// File: rtl/lsu.sv
// Multi-cycle load/store unit: one request at a time, masked memory beats, aligned and extended load data.
// Build option LSU_MISALIGN_SPLIT_EN splits accesses that cross a beat boundary into two beats.
module lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic              req_is_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [XLEN/8-1:0] mem_wmask,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB  = XLEN / 8;
   localparam int OFF = $clog2(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [OFF-1:0]    off_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              store_q;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic              split_q;
   logic [NB-1:0]     mask_hi_q;
   logic [XLEN-1:0]   wdata_hi_q;
   logic [XLEN-1:0]   lo_q;
`endif

   logic [OFF-1:0]    req_off;
   logic [2*NB-1:0]   lane_mask;
   logic              size_bad;
   logic              crosses;
   logic              req_err;
`ifndef LSU_MISALIGN_SPLIT_EN
   logic [OFF-1:0]    align_mask;
   logic              misaligned;
`endif

   // Lane mask spans two beats so the spill into the next beat falls out of one shift.
   always_comb begin
      req_off   = req_addr[OFF-1:0];
      size_bad  = (int'(req_size) > OFF);
      lane_mask = '0;
      for (int i = 0; i < NB; i++)
         if (i < (1 << req_size)) lane_mask[i] = 1'b1;
      lane_mask = lane_mask << req_off;
      crosses   = |lane_mask[2*NB-1:NB];
`ifdef LSU_MISALIGN_SPLIT_EN
      req_err   = size_bad;
`else
      align_mask = '0;
      for (int i = 0; i < OFF; i++)
         if (i < int'(req_size)) align_mask[i] = 1'b1;
      misaligned = |(req_off & align_mask);
      req_err    = size_bad | misaligned | crosses;
`endif
   end

   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] lo,
                                                   input logic [XLEN-1:0] hi,
                                                   input logic [OFF-1:0]  off,
                                                   input logic [1:0]      size,
                                                   input logic            uns);
      logic [2*XLEN-1:0] both;
      logic [XLEN-1:0]   res;
      logic              sign;
      int                base;
      int                nbits;
      both  = {hi, lo};
      base  = 8 * int'(off);
      nbits = 8 << size;
      sign  = ~uns & both[base + nbits - 1];
      for (int i = 0; i < XLEN; i++)
         res[i] = (i < nbits) ? both[base + i] : sign;
      return res;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_we        <= 1'b0;
         mem_wmask     <= '0;
         mem_wdata     <= '0;
         base_q        <= '0;
         off_q         <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         store_q       <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         split_q       <= 1'b0;
         mask_hi_q     <= '0;
         wdata_hi_q    <= '0;
         lo_q          <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               base_q    <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
               off_q     <= req_off;
               size_q    <= req_size;
               uns_q     <= req_unsigned;
               store_q   <= req_is_store;
               if (req_err) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  state         <= REQ0;
                  mem_req_valid <= 1'b1;
                  mem_addr      <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                  mem_we        <= req_is_store;
                  mem_wmask     <= req_is_store ? lane_mask[NB-1:0] : '0;
                  mem_wdata     <= req_is_store ? (req_wdata << {req_off, 3'b000}) : '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                  split_q       <= crosses;
                  mask_hi_q     <= req_is_store ? lane_mask[2*NB-1:NB] : '0;
                  wdata_hi_q    <= req_is_store ? (req_wdata >> (XLEN - 8 * int'(req_off))) : '0;
`endif
               end
            end
            REQ0: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               state         <= WAIT0;
            end
            WAIT0: if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
               lo_q <= mem_rdata;
               if (split_q) begin
                  state         <= REQ1;
                  mem_req_valid <= 1'b1;
                  mem_addr      <= base_q + ADDR_W'(NB);
                  mem_wmask     <= mask_hi_q;
                  mem_wdata     <= wdata_hi_q;
               end else
`endif
               begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= store_q ? '0 : load_extend(mem_rdata, '0, off_q, size_q, uns_q);
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ1: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               state         <= WAIT1;
            end
            WAIT1: if (mem_rsp_valid) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= store_q ? '0 : load_extend(lo_q, mem_rdata, off_q, size_q, uns_q);
            end
`endif
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu (XLEN=32): vector table plus hand-written stall/reset sequence.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined for the build.
module tb_lsu;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              req_is_store;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [3:0]        mem_wmask;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_rsp_valid = 1'b0;
   logic [XLEN-1:0]   mem_rdata = '0;

   always #5 clk = ~clk;

   lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_is_store(req_is_store), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory model: logs every beat handshake, answers one cycle later.
   logic [31:0] log_addr [4];
   logic [3:0]  log_mask [4];
   logic [31:0] log_wdata[4];
   logic        log_we   [4];
   int          beat_cnt = 0;
   int          mrv_cnt  = 0;
   bit          hs_pending = 0;
   int          op_base  = 0;
   logic [31:0] cur_rd0 = '0, cur_rd1 = '0;
   bit          suppress = 0;
   bit          stray    = 0;

   always @(posedge clk) begin
      hs_pending = 0;
      if (mem_req_valid) mrv_cnt++;
      if (mem_req_valid && mem_req_ready) begin
         log_addr[beat_cnt % 4]  = mem_addr;
         log_mask[beat_cnt % 4]  = mem_wmask;
         log_wdata[beat_cnt % 4] = mem_wdata;
         log_we[beat_cnt % 4]    = mem_we;
         beat_cnt++;
         hs_pending = 1;
      end
   end

   always @(negedge clk) begin
      mem_rsp_valid = (hs_pending && !suppress) || stray;
      mem_rdata     = ((beat_cnt - op_base) >= 2) ? cur_rd1 : cur_rd0;
   end

   typedef struct {
      string       name;
      logic        st;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_beats;
      int          exp_lat;
      logic [31:0] a0;
      logic [3:0]  m0;
      logic [31:0] w0;
      logic [31:0] a1;
      logic [3:0]  m1;
      logic [31:0] w1;
   } vec_t;

   function automatic vec_t mk(input string name, input logic st, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rd0, input logic [31:0] rd1,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_beats, input int exp_lat,
                               input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                               input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1);
      vec_t v;
      v.name = name; v.st = st; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.rd0 = rd0; v.rd1 = rd1; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      v.exp_beats = exp_beats; v.exp_lat = exp_lat;
      v.a0 = a0; v.m0 = m0; v.w0 = w0; v.a1 = a1; v.m1 = m1; v.w1 = w1;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int  base_mrv;
      int  lat;
      bit  got;
      @(negedge clk);
      check({v.name, " req_ready idle"}, req_ready, 1);
      op_base      = beat_cnt;
      base_mrv     = mrv_cnt;
      cur_rd0      = v.rd0;
      cur_rd1      = v.rd1;
      req_valid    = 1'b1;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_is_store = v.st;
      req_size     = v.size;
      req_unsigned = v.uns;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) got = 1;
      end
      if (!got) begin
         check({v.name, " rsp timeout"}, 0, 1);
         return;
      end
      check({v.name, " latency"}, lat, v.exp_lat);
      check({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
      check({v.name, " err"}, rsp_err, v.exp_err);
      check({v.name, " req_ready busy"}, req_ready, 0);
      check({v.name, " beats"}, beat_cnt - op_base, v.exp_beats);
      if (v.exp_beats == 0) check({v.name, " no mem_req_valid"}, mrv_cnt - base_mrv, 0);
      if (v.exp_beats >= 1) begin
         check({v.name, " addr0"}, log_addr[op_base % 4], v.a0);
         check({v.name, " mask0"}, log_mask[op_base % 4], v.m0);
         check({v.name, " we0"}, log_we[op_base % 4], v.st);
         if (v.st) check({v.name, " wdata0"}, log_wdata[op_base % 4], v.w0);
      end
      if (v.exp_beats >= 2) begin
         check({v.name, " addr1"}, log_addr[(op_base + 1) % 4], v.a1);
         check({v.name, " mask1"}, log_mask[(op_base + 1) % 4], v.m1);
         check({v.name, " we1"}, log_we[(op_base + 1) % 4], v.st);
         if (v.st) check({v.name, " wdata1"}, log_wdata[(op_base + 1) % 4], v.w1);
      end
      @(negedge clk);
      check({v.name, " rsp one cycle"}, rsp_valid, 0);
      check({v.name, " req_ready back"}, req_ready, 1);
   endtask

   vec_t vecs[$];

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_is_store = 1'b0;
      req_size = 2'd0; req_unsigned = 1'b0;
      mem_req_ready = 1'b1;

      vecs.push_back(mk("LW 0x100", 0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1, 3,
                        32'h100, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk("LB 0x103", 0, 0, 0, 32'h103, 0, 32'h80FFFFFF, 0, 32'hFFFFFF80, 0, 1, 3,
                        32'h100, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk("LBU 0x103", 0, 0, 1, 32'h103, 0, 32'h80FFFFFF, 0, 32'h00000080, 0, 1, 3,
                        32'h100, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk("SH 0x102", 1, 1, 0, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 1, 3,
                        32'h100, 4'hC, 32'hABCD0000, 0, 0, 0));
      vecs.push_back(mk("LH 0x102", 0, 1, 0, 32'h102, 0, 32'h80010000, 0, 32'hFFFF8001, 0, 1, 3,
                        32'h100, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk("LHU 0x102", 0, 1, 1, 32'h102, 0, 32'h80010000, 0, 32'h00008001, 0, 1, 3,
                        32'h100, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk("SB 0x101", 1, 0, 0, 32'h101, 32'h000000AB, 0, 0, 0, 0, 1, 3,
                        32'h100, 4'h2, 32'h0000AB00, 0, 0, 0));
      vecs.push_back(mk("SW 0x104", 1, 2, 0, 32'h104, 32'hCAFEF00D, 0, 0, 0, 0, 1, 3,
                        32'h104, 4'hF, 32'hCAFEF00D, 0, 0, 0));
      vecs.push_back(mk("LD size3 0x103", 0, 3, 0, 32'h103, 0, 0, 0, 0, 1, 0, 1,
                        0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("LD size3 0x100", 0, 3, 0, 32'h100, 0, 0, 0, 0, 1, 0, 1,
                        0, 0, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
      vecs.push_back(mk("SW 0x103 split", 1, 2, 0, 32'h103, 32'h11223344, 0, 0, 0, 0, 2, 5,
                        32'h100, 4'h8, 32'h44000000, 32'h104, 4'h7, 32'h00112233));
      vecs.push_back(mk("LH 0x103 split", 0, 1, 0, 32'h103, 0, 32'h12000000, 32'h000000F0,
                        32'hFFFFF012, 0, 2, 5, 32'h100, 4'h0, 0, 32'h104, 4'h0, 0));
      vecs.push_back(mk("LH 0x101 in-beat", 0, 1, 0, 32'h101, 0, 32'h00ABCD00, 0, 32'hFFFFABCD,
                        0, 1, 3, 32'h100, 4'h0, 0, 0, 0, 0));
`else
      vecs.push_back(mk("SW 0x103 err", 1, 2, 0, 32'h103, 32'h11223344, 0, 0, 0, 1, 0, 1,
                        0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("LH 0x103 err", 0, 1, 0, 32'h103, 0, 32'h12000000, 32'h000000F0, 0, 1,
                        0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("LH 0x101 err", 0, 1, 0, 32'h101, 0, 32'h00ABCD00, 0, 0, 1, 0, 1,
                        0, 0, 0, 0, 0, 0));
`endif

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("reset req_ready", req_ready, 1);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rsp_rdata", rsp_rdata, 0);
      check("reset rsp_err", rsp_err, 0);
      check("reset mem_req_valid", mem_req_valid, 0);
      check("reset mem_addr", mem_addr, 0);
      check("reset mem_we", mem_we, 0);
      check("reset mem_wmask", mem_wmask, 0);
      check("reset mem_wdata", mem_wdata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Memory stall in REQ0, then reset in WAIT0 and a stray memory response
      @(negedge clk);
      mem_req_ready = 1'b0;
      op_base      = beat_cnt;
      req_valid    = 1'b1;
      req_addr     = 32'h200;
      req_wdata    = '0;
      req_is_store = 1'b0;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall mem_req_valid", mem_req_valid, 1);
         check("stall mem_addr", mem_addr, 32'h200);
         check("stall mem_we", mem_we, 0);
         check("stall mem_wmask", mem_wmask, 0);
         check("stall req_ready", req_ready, 0);
      end
      suppress = 1;
      mem_req_ready = 1'b1;
      @(posedge clk);
      #1 check("stall handshake done", mem_req_valid, 0);
      check("stall beat count", beat_cnt - op_base, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst req_ready", req_ready, 1);
      check("midrst mem_req_valid", mem_req_valid, 0);
      check("midrst rsp_valid", rsp_valid, 0);
      check("midrst mem_addr", mem_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      #2 stray = 1;
      @(negedge clk);
      #2 stray = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray rsp_valid", rsp_valid, 0);
         check("stray req_ready", req_ready, 1);
         check("stray mem_req_valid", mem_req_valid, 0);
      end
      suppress = 0;
      run_vec(mk("LW after reset", 0, 2, 0, 32'h100, 0, 32'h13579BDF, 0, 32'h13579BDF, 0, 1, 3,
                 32'h100, 4'h0, 0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
